// File: rtl/spi_minion_pkg.sv
// Shared types and constants for the SPI minion pin-facing front end.
// The FSM state encoding, synchroniser depth and parity helper all live here.
package spi_minion_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    localparam int SYNC_DEPTH   = 2;
    localparam int PARITY_MAX_W = 64;

    // Zero-extension does not change the XOR, so narrower frames can share this helper.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, followed by a history flop.
// The history flop provides the rise and fall edge strobes.
module spi_pin_sync
    import spi_minion_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    // Stage 0 is s1, stage SYNC_DEPTH-1 is s2, stage SYNC_DEPTH is the history flop s3.
    logic [SYNC_DEPTH:0] sync_r;

    // Shift the pin through the synchroniser and history stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {(SYNC_DEPTH + 1){RESET_VAL}};
        end else begin
            sync_r <= {sync_r[SYNC_DEPTH-1:0], pin};
        end
    end

    assign level = sync_r[SYNC_DEPTH-1];
    assign rise  = sync_r[SYNC_DEPTH-1] & ~sync_r[SYNC_DEPTH];
    assign fall  = ~sync_r[SYNC_DEPTH-1] & sync_r[SYNC_DEPTH];

endmodule

// File: rtl/spi_minion_frontend.sv
// SPI mode-0 minion front end: it synchronises the pads, shifts one frame per chip-select
// window, pushes each complete frame and pulls the next word to shift out.
module spi_minion_frontend
    import spi_minion_pkg::*;
#(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs,
    input  logic                 sclk,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 push_en,
    output logic [BIT_WIDTH-1:0] push_msg,
    output logic                 pull_en,
    input  logic [BIT_WIDTH-1:0] pull_msg,
    output logic                 minion_parity,
    output logic                 frame_err
);

    localparam int CNT_W = $clog2(BIT_WIDTH + 2);

    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic sclk_rise_s, sclk_fall_s, sclk_level_unused_s;
    logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;

    state_t               state_r, state_next_s;
    logic [BIT_WIDTH-1:0] sr_r, sr_next_s;
    logic [CNT_W-1:0]     cnt_r, cnt_next_s;
    logic                 miso_r, miso_next_s;
    logic                 push_en_r, push_en_next_s;
    logic                 pull_en_r, pull_en_next_s;
    logic [BIT_WIDTH-1:0] push_msg_r, push_msg_next_s;
    logic                 parity_r, parity_next_s;
    logic                 frame_err_r, frame_err_next_s;

    spi_pin_sync #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (cs),
        .level (cs_level_s),
        .rise  (cs_rise_s),
        .fall  (cs_fall_s)
    );

    spi_pin_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (sclk),
        .level (sclk_level_unused_s),
        .rise  (sclk_rise_s),
        .fall  (sclk_fall_s)
    );

    spi_pin_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (mosi),
        .level (mosi_s),
        .rise  (mosi_rise_unused_s),
        .fall  (mosi_fall_unused_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= WAIT_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath decode. In WAIT_IDLE the bit counter times the synchroniser
    // flush, so reset values in the cs flops cannot fake an idle bus.
    always_comb begin
        state_next_s     = state_r;
        sr_next_s        = sr_r;
        cnt_next_s       = cnt_r;
        miso_next_s      = miso_r;
        push_en_next_s   = 1'b0;
        pull_en_next_s   = 1'b0;
        push_msg_next_s  = push_msg_r;
        parity_next_s    = parity_r;
        frame_err_next_s = frame_err_r;

        case (state_r)
            WAIT_IDLE: begin
                if (cnt_r != CNT_W'(SYNC_DEPTH + 1)) begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end else if (cs_level_s) begin
                    state_next_s = IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    state_next_s = WAIT_IDLE;
                end
            end
            IDLE: begin
                if (cs_fall_s) begin
                    state_next_s   = ACTIVE;
                    pull_en_next_s = 1'b1;
                    sr_next_s      = pull_msg;
                    cnt_next_s     = {CNT_W{1'b0}};
                    miso_next_s    = pull_msg[BIT_WIDTH-1];
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACTIVE: begin
                // A cs release outranks any sclk edge that arrives in the same cycle.
                if (cs_rise_s) begin
                    state_next_s = IDLE;
                    if (cnt_r == CNT_W'(BIT_WIDTH)) begin
                        push_en_next_s  = 1'b1;
                        push_msg_next_s = sr_r;
                        parity_next_s   = even_parity(PARITY_MAX_W'(sr_r));
                    end else begin
                        frame_err_next_s = 1'b1;
                    end
                end else if (sclk_rise_s) begin
                    sr_next_s = {sr_r[BIT_WIDTH-2:0], mosi_s};
                    if (cnt_r != CNT_W'(BIT_WIDTH + 1)) begin
                        cnt_next_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end else if (sclk_fall_s) begin
                    miso_next_s = sr_r[BIT_WIDTH-1];
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            default: begin
                state_next_s = WAIT_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_r        <= {BIT_WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            miso_r      <= 1'b0;
            push_en_r   <= 1'b0;
            pull_en_r   <= 1'b0;
            push_msg_r  <= {BIT_WIDTH{1'b0}};
            parity_r    <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            sr_r        <= sr_next_s;
            cnt_r       <= cnt_next_s;
            miso_r      <= miso_next_s;
            push_en_r   <= push_en_next_s;
            pull_en_r   <= pull_en_next_s;
            push_msg_r  <= push_msg_next_s;
            parity_r    <= parity_next_s;
            frame_err_r <= frame_err_next_s;
        end
    end

    assign miso          = miso_r;
    assign push_en       = push_en_r;
    assign pull_en       = pull_en_r;
    assign push_msg      = push_msg_r;
    assign minion_parity = parity_r;
    assign frame_err     = frame_err_r;

endmodule

// File: tb/tb_spi_minion_frontend.sv
// Directed bench for spi_minion_frontend: it bit-bangs SPI mode-0 frames on the pads
// and compares pushes, pulls, miso, parity and frame_err with hand-computed values.
module tb_spi_minion_frontend;

    logic       clk = 1'b0;
    logic       reset, cs, sclk, mosi;
    logic       miso, push_en, pull_en, minion_parity, frame_err;
    logic [7:0] push_msg, pull_msg;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         push_cnt = 0;
    int         pull_cnt = 0;
    int         last_push_cyc = 0;
    int         rise_cyc = 0;
    logic [7:0] last_push_val = 8'h00;

    always #5 clk = ~clk;

    spi_minion_frontend #(.BIT_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .cs            (cs),
        .sclk          (sclk),
        .mosi          (mosi),
        .miso          (miso),
        .push_en       (push_en),
        .push_msg      (push_msg),
        .pull_en       (pull_en),
        .pull_msg      (pull_msg),
        .minion_parity (minion_parity),
        .frame_err     (frame_err)
    );

    // Advance n clocks, sampling 1 time unit after each rising edge and logging pulses.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (push_en === 1'b1) begin
                push_cnt++;
                last_push_cyc = cyc;
                last_push_val = push_msg;
            end
            if (pull_en === 1'b1) pull_cnt++;
        end
    endtask

    // One chip-select frame with nbits sclk pulses; miso is sampled just before each rise.
    task automatic run_frame(input logic [7:0] data, input logic [7:0] pull, input int nbits,
                             input bit coincident, input int gap, output logic [7:0] miso_seen);
        miso_seen = 8'h00;
        pull_msg  = pull;
        cs        = 1'b0;
        step(5);
        for (int i = 0; i < nbits; i++) begin
            mosi = data[7-i];
            step(2);
            miso_seen[7-i] = miso;
            sclk = 1'b1;
            step(4);
            sclk = 1'b0;
            step(4);
        end
        if (coincident) begin
            mosi = 1'b1;
            step(2);
            sclk = 1'b1;
            cs   = 1'b1;
        end else begin
            cs = 1'b1;
        end
        rise_cyc = cyc;
        step(gap);
        if (coincident) begin
            sclk = 1'b0;
            step(4);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        cs       = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        pull_msg = 8'h00;
        step(3);
        vectors++; if (miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got %b want 0", miso); end
        vectors++; if (push_en !== 1'b0) begin miscompares++; $display("FAIL reset_push_en: got %b want 0", push_en); end
        vectors++; if (pull_en !== 1'b0) begin miscompares++; $display("FAIL reset_pull_en: got %b want 0", pull_en); end
        vectors++; if (push_msg !== 8'h00) begin miscompares++; $display("FAIL reset_push_msg: got %h want 00", push_msg); end
        vectors++; if (minion_parity !== 1'b0) begin miscompares++; $display("FAIL reset_parity: got %b want 0", minion_parity); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        reset = 1'b0;
        step(8);
    endtask

    task automatic test_basic_frame();
        logic [7:0] seen;
        push_cnt = 0;
        pull_cnt = 0;
        run_frame(8'hA5, 8'h3C, 8, 1'b0, 6, seen);
        vectors++; if (pull_cnt != 1) begin miscompares++; $display("FAIL basic_pull_count: got %0d want 1", pull_cnt); end
        vectors++; if (seen !== 8'h3C) begin miscompares++; $display("FAIL basic_miso: got %h want 3c", seen); end
        vectors++; if (push_msg !== 8'hA5) begin miscompares++; $display("FAIL basic_push_msg: got %h want a5", push_msg); end
        vectors++; if (minion_parity !== 1'b0) begin miscompares++; $display("FAIL basic_parity: got %b want 0", minion_parity); end
        vectors++; if (push_cnt != 1) begin miscompares++; $display("FAIL basic_push_count: got %0d want 1", push_cnt); end
        vectors++; if (last_push_cyc - rise_cyc != 3) begin miscompares++; $display("FAIL basic_push_latency: got %0d want 3", last_push_cyc - rise_cyc); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL basic_frame_err: got %b want 0", frame_err); end
    endtask

    task automatic test_parity();
        logic [7:0] seen;
        run_frame(8'h01, 8'hF0, 8, 1'b0, 6, seen);
        vectors++; if (push_msg !== 8'h01) begin miscompares++; $display("FAIL parity_push_01: got %h want 01", push_msg); end
        vectors++; if (minion_parity !== 1'b1) begin miscompares++; $display("FAIL parity_01: got %b want 1", minion_parity); end
        step(10);
        vectors++; if (push_msg !== 8'h01) begin miscompares++; $display("FAIL parity_hold_01: got %h want 01", push_msg); end
        run_frame(8'hFF, 8'h0F, 8, 1'b0, 6, seen);
        vectors++; if (push_msg !== 8'hFF) begin miscompares++; $display("FAIL parity_push_ff: got %h want ff", push_msg); end
        vectors++; if (minion_parity !== 1'b0) begin miscompares++; $display("FAIL parity_ff: got %b want 0", minion_parity); end
        vectors++; if (seen !== 8'h0F) begin miscompares++; $display("FAIL parity_miso: got %h want 0f", seen); end
    endtask

    task automatic test_short_frame();
        logic [7:0] seen;
        push_cnt = 0;
        run_frame(8'h77, 8'h00, 7, 1'b0, 6, seen);
        vectors++; if (push_cnt != 0) begin miscompares++; $display("FAIL short_no_push: got %0d want 0", push_cnt); end
        vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL short_frame_err: got %b want 1", frame_err); end
        vectors++; if (push_msg !== 8'hFF) begin miscompares++; $display("FAIL short_push_hold: got %h want ff", push_msg); end
        run_frame(8'h5A, 8'h00, 8, 1'b0, 6, seen);
        vectors++; if (push_msg !== 8'h5A) begin miscompares++; $display("FAIL short_next_push: got %h want 5a", push_msg); end
        vectors++; if (push_cnt != 1) begin miscompares++; $display("FAIL short_next_count: got %0d want 1", push_cnt); end
        vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL short_err_sticky: got %b want 1", frame_err); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] seen;
        pull_msg = 8'h00;
        cs = 1'b0;
        step(5);
        sclk = 1'b1;
        step(4);
        sclk = 1'b0;
        step(2);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        push_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            mosi = i[0];
            step(2);
            sclk = 1'b1;
            step(4);
            sclk = 1'b0;
            step(4);
        end
        cs = 1'b1;
        step(8);
        vectors++; if (push_cnt != 0) begin miscompares++; $display("FAIL midreset_no_push: got %0d want 0", push_cnt); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL midreset_frame_err: got %b want 0", frame_err); end
        vectors++; if (push_msg !== 8'h00) begin miscompares++; $display("FAIL midreset_push_msg: got %h want 00", push_msg); end
        run_frame(8'hC3, 8'h96, 8, 1'b0, 6, seen);
        vectors++; if (push_msg !== 8'hC3) begin miscompares++; $display("FAIL midreset_recover: got %h want c3", push_msg); end
        vectors++; if (push_cnt != 1) begin miscompares++; $display("FAIL midreset_recover_count: got %0d want 1", push_cnt); end
        vectors++; if (seen !== 8'h96) begin miscompares++; $display("FAIL midreset_miso: got %h want 96", seen); end
    endtask

    task automatic test_idle_sclk_and_coincident();
        logic [7:0] seen;
        push_cnt = 0;
        pull_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            mosi = 1'b1;
            sclk = 1'b1;
            step(4);
            sclk = 1'b0;
            step(4);
        end
        vectors++; if (push_cnt != 0) begin miscompares++; $display("FAIL idle_sclk_push: got %0d want 0", push_cnt); end
        vectors++; if (pull_cnt != 0) begin miscompares++; $display("FAIL idle_sclk_pull: got %0d want 0", pull_cnt); end
        vectors++; if (push_msg !== 8'hC3) begin miscompares++; $display("FAIL idle_sclk_hold: got %h want c3", push_msg); end
        run_frame(8'h81, 8'h5A, 8, 1'b1, 6, seen);
        vectors++; if (push_cnt != 1) begin miscompares++; $display("FAIL coincident_push_count: got %0d want 1", push_cnt); end
        vectors++; if (push_msg !== 8'h81) begin miscompares++; $display("FAIL coincident_push_msg: got %h want 81", push_msg); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL coincident_frame_err: got %b want 0", frame_err); end
        vectors++; if (minion_parity !== 1'b0) begin miscompares++; $display("FAIL coincident_parity: got %b want 0", minion_parity); end
        vectors++; if (seen !== 8'h5A) begin miscompares++; $display("FAIL coincident_miso: got %h want 5a", seen); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, p, seen;
        int         pc;
        for (int f = 0; f < 100; f++) begin
            d  = 8'($urandom_range(0, 255));
            p  = 8'($urandom_range(0, 255));
            pc = push_cnt;
            run_frame(d, p, 8, 1'b0, 4, seen);
            vectors++; if (push_cnt != pc + 1) begin miscompares++; $display("FAIL b2b_count f%0d: got %0d want %0d", f, push_cnt, pc + 1); end
            vectors++; if (last_push_val !== d) begin miscompares++; $display("FAIL b2b_data f%0d: got %h want %h", f, last_push_val, d); end
            vectors++; if (seen !== p) begin miscompares++; $display("FAIL b2b_miso f%0d: got %h want %h", f, seen, p); end
            vectors++; if (minion_parity !== ^d) begin miscompares++; $display("FAIL b2b_parity f%0d: got %b want %b", f, minion_parity, ^d); end
        end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL b2b_frame_err: got %b want 0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_short_frame();
        test_reset_midframe();
        test_idle_sclk_and_coincident();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_minion_frontend.md
# spi_minion_frontend

Pin-facing SPI minion stage that sits directly between the raw `cs`/`sclk`/`mosi`/`miso` pins of the user wrapper and the interconnect's message adapter. It synchronises the asynchronous SPI pins into `clk`, runs SPI mode 0, and converts each chip-select frame into one pushed message. It loads one pulled message for shift-out and reports the even parity of the last received frame on `minion_parity`.

## Interface
- `BIT_WIDTH`, 8: frame length in bits; the push and pull message width.
- `clk` in 1: system clock, the Wishbone clock.
- `reset` in 1: synchronous, active-high.
- `cs` in 1: chip select from the pad, active low, asynchronous.
- `sclk` in 1: SPI clock from the pad, asynchronous.
- `mosi` in 1: serial data in, asynchronous.
- `miso` out 1: serial data out, registered.
- `push_en` out 1: one-cycle pulse; `push_msg` is valid in that cycle.
- `push_msg` out BIT_WIDTH: last complete received frame, MSB first on the wire.
- `pull_en` out 1: one-cycle pulse; `pull_msg` is sampled in that cycle.
- `pull_msg` in BIT_WIDTH: word to shift out in the next frame.
- `minion_parity` out 1: XOR of all bits of the last pushed frame.
- `frame_err` out 1: sticky; set when a frame does not contain exactly BIT_WIDTH bits; cleared only by reset.

## Operation
- Synchroniser: `cs`, `sclk` and `mosi` each pass through 2 flops (s1, s2) followed by a history flop (s3).
  - Edge for `cs`/`sclk` is detected when s2 != s3.
  - `mosi` is sampled from its s2 in the same cycle as the edge is detected.
- FSM states: WAIT_IDLE, IDLE, ACTIVE.
  - WAIT_IDLE is entered on reset. Moves to IDLE once synced `cs` = 1. Falling `cs` is ignored here, so a frame is never joined mid-stream.
  - IDLE → ACTIVE on a `cs` falling edge. In that cycle: pulse `pull_en`, load the shift register with `pull_msg`, clear the bit counter, drive `miso` = `pull_msg[BIT_WIDTH-1]`.
  - ACTIVE, `sclk` rising edge: shift register ← {sr[BIT_WIDTH-2:0], mosi_s2}; counter += 1. The counter saturates at BIT_WIDTH+1.
  - ACTIVE, `sclk` falling edge: `miso` ← sr[BIT_WIDTH-1].
  - ACTIVE → IDLE on a `cs` rising edge.
    - If counter == BIT_WIDTH: pulse `push_en` with `push_msg` = sr, and update `minion_parity` = ^sr in the same cycle.
    - Otherwise: no push, set `frame_err`; `push_msg` and `minion_parity` are unchanged.
- Simultaneous `cs` rising and `sclk` edge in the same cycle: `cs` wins and the `sclk` edge is ignored.
- `sclk` edges in IDLE or WAIT_IDLE are ignored.
- `push_msg` holds its value between pushes.

## Timing
- Reset values:
  - Outputs: `miso` 0, `push_en` 0, `pull_en` 0, `push_msg` 0, `minion_parity` 0, `frame_err` 0.
  - Internal: shift register 0, counter 0.
  - Synchroniser `cs` flops reset to 1; `sclk` and `mosi` flops reset to 0.
- Pin-to-action latency: a pin change registered at clk edge n is in s2 after edge n+1 and is acted on at edge n+2. Every action is therefore 3 clk edges after the pin transition, ±1 for sampling phase.
- `push_en` asserts 3 cycles after `cs` rises. `pull_en` asserts 3 cycles after `cs` falls.
- `miso` updates 3 cycles after a falling `sclk`.
- Constraint on the master: sclk high and low phases ≥ 4 clk each. The first sclk rise must come ≥ 4 clk after cs falls, and cs must rise ≥ 4 clk after the last sclk fall.
- `pull_msg` must be valid in the `pull_en` cycle; there is no backpressure on `push_en`.
- Reset asserted mid-frame: the frame is discarded with no push and no error. The block returns to WAIT_IDLE and stays there until `cs` is released.

## Structure
- Package `spi_minion_pkg`:
  - FSM state enum {WAIT_IDLE, IDLE, ACTIVE}.
  - Localparam for synchroniser depth (2).
- Sub-module `spi_pin_sync`: 2-flop synchroniser plus history flop, with outputs `rise`/`fall`/`level` and a parameterised reset value. It is instantiated three times; `mosi` uses only `level`.
- Top-level module holds the FSM, shift register, counter and output registers.

## Test plan
- Reset with `cs` = 1, then a frame with `mosi` = 0xA5 and `pull_msg` = 0x3C: `pull_en` pulses once; `miso` bits read back 0x3C; `push_msg` = 0xA5; `minion_parity` = 0; `push_en` pulses once, 3 cycles after `cs` rises.
- Frame 0x01, then frame 0xFF: `minion_parity` is 1, then 0; `push_msg` holds 0x01 until the second push.
- Short frame of 7 sclk pulses: no `push_en`; `frame_err` = 1; `push_msg` unchanged. A following good 8-bit frame 0x5A still pushes 0x5A with `frame_err` still 1.
- Hold `cs` low and pulse `reset` for 2 cycles mid-frame, then toggle sclk 8 times: no push. After `cs` goes high, a new frame 0xC3 pushes 0xC3.
- `sclk` toggling while `cs` is high, and `cs` rising in the same clk as an sclk rise: no state change, and the counter is not incremented by the coincident edge.
- Back-to-back frames with the minimum 4-clk spacing, random data ×100: every frame pushed intact and `miso` matches `pull_msg`.
